dsp19x2_split_mac: RTL and testbench

Cycle-accurate behavioural core for the packed, register-input dual multiply-accumulate cell that DSP19X2 maps onto. It consumes the concatenated two-lane buses `{lane1, lane2}` and produces the packed `z`/`dly_b` results. It is the simulation and reconstruction counterpart used when gate-level netlists containing the split 10x9 DSP are read back and verified. Each lane is an independent 10x9 multiplier with coefficient select, a 32-bit accumulator, shift/round and optional saturation; the two lanes share all control inputs.

---
 rtl/dsp19x2_split_mac_if.sv | 28 ++
 rtl/dsp19x2_split_mac.sv | 176 +++++++++++++++++
 tb/tb_dsp19x2_split_mac.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp19x2_split_mac_if.sv
// Two-lane bus for dsp19x2_split_mac: packed {lane1, lane2} operands, shared controls and packed results.
interface dsp19x2_split_mac_if;
   logic [19:0] a;
   logic [17:0] b;
   logic [37:0] z;
   logic [17:0] dly_b;
   logic [2:0]  feedback;
   logic        unsigned_a;
   logic        unsigned_b;
   logic [4:0]  acc_fir;
   logic        load_acc;
   logic        saturate_enable;
   logic [4:0]  shift_right;
   logic        round;
   logic        subtract;

   modport master (
      output a, b, feedback, unsigned_a, unsigned_b, acc_fir, load_acc,
             saturate_enable, shift_right, round, subtract,
      input  z, dly_b
   );

   modport slave (
      input  a, b, feedback, unsigned_a, unsigned_b, acc_fir, load_acc,
             saturate_enable, shift_right, round, subtract,
      output z, dly_b
   );
endinterface

// File: rtl/dsp19x2_split_mac.sv
// Dual-lane 10x9 multiply-accumulate core behind the split DSP19X2 cell.
// Optional output clamping is built only when DSP19X2_SPLIT_MAC_SAT_EN is defined.
module dsp19x2_split_mac #(
   parameter logic [39:0] COEFF1     = 40'h0,
   parameter logic [39:0] COEFF2     = 40'h0,
   parameter int unsigned ACCUMULATE = 1,
   parameter int unsigned INPUT_REG  = 1,
   parameter int unsigned OUTPUT_REG = 0
) (
   input logic                clk,
   input logic                lreset,
   dsp19x2_split_mac_if.slave bus
);

   typedef struct packed {
      logic [19:0] a;
      logic [17:0] b;
      logic [2:0]  feedback;
      logic        unsigned_a;
      logic        unsigned_b;
      logic [4:0]  acc_fir;
      logic        load_acc;
`ifdef DSP19X2_SPLIT_MAC_SAT_EN
      logic        saturate_enable;
`endif
      logic [4:0]  shift_right;
      logic        round;
      logic        subtract;
   } ctrl_t;

   typedef struct packed {
      logic [4:0] shift_right;
      logic       round;
`ifdef DSP19X2_SPLIT_MAC_SAT_EN
      logic       saturate_enable;
      logic       unsigned_a;
      logic       unsigned_b;
`endif
   } post_t;

   function automatic logic [9:0] coeff_sel(input logic [39:0] coeff, input logic [1:0] idx);
      logic [9:0] c;
      case (idx)
         2'd0:    c = coeff[9:0];
         2'd1:    c = coeff[19:10];
         2'd2:    c = coeff[29:20];
         default: c = coeff[39:30];
      endcase
      return c;
   endfunction

   function automatic logic signed [31:0] lane_d(input logic [9:0] av, input logic [8:0] bv,
                                                 input logic [39:0] coeff, input ctrl_t c);
      logic [9:0]         op_a;
      logic signed [10:0] ae;
      logic signed [9:0]  be;
      logic signed [20:0] p;
      logic signed [31:0] q;
      op_a = c.feedback[2] ? coeff_sel(coeff, c.feedback[1:0]) : av;
      // One extra bit per operand lets a single signed multiply cover every signedness mix
      ae = {~c.unsigned_a & op_a[9], op_a};
      be = {~c.unsigned_b & bv[8], bv};
      p  = ae * be;
      q  = 32'(p) <<< c.acc_fir;
      return c.subtract ? -q : q;
   endfunction

   function automatic logic [18:0] lane_out(input logic signed [31:0] x, input post_t c);
      logic signed [32:0] rnd;
      logic signed [32:0] s;
      rnd = (c.round && c.shift_right != 5'd0) ? (33'sd1 <<< (c.shift_right - 5'd1)) : '0;
      s   = (33'(x) + rnd) >>> c.shift_right;
`ifdef DSP19X2_SPLIT_MAC_SAT_EN
      if (c.saturate_enable) begin
         if (c.unsigned_a && c.unsigned_b) begin
            if (s < 0) s = '0;
            else if (s > 33'sd524287) s = 33'sd524287;
         end else begin
            if (s < -33'sd262144) s = -33'sd262144;
            else if (s > 33'sd262143) s = 33'sd262143;
         end
      end
`endif
      return s[18:0];
   endfunction

   ctrl_t              in_raw;
   ctrl_t              st0;
   post_t              post_now;
   post_t              post;
   logic signed [31:0] d1, d2, x1, x2;
   logic [37:0]        z_next;
   logic [17:0]        dly_q;

   always_comb begin
      in_raw             = '0;
      in_raw.a           = bus.a;
      in_raw.b           = bus.b;
      in_raw.feedback    = bus.feedback;
      in_raw.unsigned_a  = bus.unsigned_a;
      in_raw.unsigned_b  = bus.unsigned_b;
      in_raw.acc_fir     = bus.acc_fir;
      in_raw.load_acc    = bus.load_acc;
`ifdef DSP19X2_SPLIT_MAC_SAT_EN
      in_raw.saturate_enable = bus.saturate_enable;
`endif
      in_raw.shift_right = bus.shift_right;
      in_raw.round       = bus.round;
      in_raw.subtract    = bus.subtract;
   end

   if (INPUT_REG != 0) begin : g_in_reg
      always_ff @(posedge clk or negedge lreset) begin
         if (!lreset) st0 <= '0;
         else         st0 <= in_raw;
      end
   end else begin : g_in_comb
      assign st0 = in_raw;
   end

   always_comb begin
      post_now             = '0;
      post_now.shift_right = st0.shift_right;
      post_now.round       = st0.round;
`ifdef DSP19X2_SPLIT_MAC_SAT_EN
      post_now.saturate_enable = st0.saturate_enable;
      post_now.unsigned_a      = st0.unsigned_a;
      post_now.unsigned_b      = st0.unsigned_b;
`endif
   end

   assign d1 = lane_d(st0.a[19:10], st0.b[17:9], COEFF1, st0);
   assign d2 = lane_d(st0.a[9:0],   st0.b[8:0],  COEFF2, st0);

   // Output-path controls travel with the accumulator so each sum is shaped by its own settings
   if (ACCUMULATE != 0) begin : g_acc
      logic signed [31:0] acc1, acc2;
      always_ff @(posedge clk or negedge lreset) begin
         if (!lreset) begin
            acc1 <= '0;
            acc2 <= '0;
            post <= '0;
         end else begin
            acc1 <= st0.load_acc ? acc1 + d1 : d1;
            acc2 <= st0.load_acc ? acc2 + d2 : d2;
            post <= post_now;
         end
      end
      assign x1 = acc1;
      assign x2 = acc2;
   end else begin : g_no_acc
      assign x1   = d1;
      assign x2   = d2;
      assign post = post_now;
   end

   assign z_next = {lane_out(x1, post), lane_out(x2, post)};

   if (OUTPUT_REG != 0) begin : g_out_reg
      logic [37:0] z_q;
      always_ff @(posedge clk or negedge lreset) begin
         if (!lreset) z_q <= '0;
         else         z_q <= z_next;
      end
      assign bus.z = z_q;
   end else begin : g_out_comb
      assign bus.z = z_next;
   end

   always_ff @(posedge clk or negedge lreset) begin
      if (!lreset) dly_q <= '0;
      else         dly_q <= st0.b;
   end
   assign bus.dly_b = dly_q;

endmodule

// File: tb/tb_dsp19x2_split_mac.sv
// Scoreboard bench for dsp19x2_split_mac: a default MAC instance plus a multiply-only, output-registered one.
module tb_dsp19x2_split_mac;

   logic        clk = 1'b0;
   logic        lreset;
   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dsp19x2_split_mac_if bus_m ();
   dsp19x2_split_mac_if bus_p ();

   dsp19x2_split_mac #(
      .COEFF1(40'h00_0000_1C00),
      .COEFF2(40'h00_000F_FC00)
   ) dut (
      .clk   (clk),
      .lreset(lreset),
      .bus   (bus_m)
   );

   dsp19x2_split_mac #(
      .ACCUMULATE(0),
      .OUTPUT_REG(1)
   ) dut_mo (
      .clk   (clk),
      .lreset(lreset),
      .bus   (bus_p)
   );

   typedef struct {
      int unsigned due;
      bit          unit;
      logic [18:0] z1;
      logic [18:0] z2;
      logic [17:0] db;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   task automatic idle_m;
      bus_m.a = '0; bus_m.b = '0; bus_m.feedback = '0;
      bus_m.unsigned_a = 1'b0; bus_m.unsigned_b = 1'b0; bus_m.acc_fir = '0;
      bus_m.load_acc = 1'b0; bus_m.saturate_enable = 1'b0; bus_m.shift_right = '0;
      bus_m.round = 1'b0; bus_m.subtract = 1'b0;
   endtask

   task automatic idle_p;
      bus_p.a = '0; bus_p.b = '0; bus_p.feedback = '0;
      bus_p.unsigned_a = 1'b0; bus_p.unsigned_b = 1'b0; bus_p.acc_fir = '0;
      bus_p.load_acc = 1'b0; bus_p.saturate_enable = 1'b0; bus_p.shift_right = '0;
      bus_p.round = 1'b0; bus_p.subtract = 1'b0;
   endtask

   task automatic push(input string name, input bit unit, input logic [18:0] z1, input logic [18:0] z2);
      exp_t e;
      e.due  = cyc + 2;
      e.unit = unit;
      e.z1   = z1;
      e.z2   = z2;
      e.db   = unit ? bus_p.b : bus_m.b;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Advance one edge, then retire every scoreboard entry due on this edge.
   task automatic tick;
      exp_t        e;
      logic [37:0] zo;
      logic [17:0] dbo;
      @(posedge clk);
      #1;
      while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
         e   = exp_q.pop_front();
         zo  = e.unit ? bus_p.z : bus_m.z;
         dbo = e.unit ? bus_p.dly_b : bus_m.dly_b;
         checks++;
         if (e.due != cyc) begin
            errors++;
            $display("FAIL %s late: checked at cycle %0d, required cycle %0d", e.name, cyc, e.due);
         end
         checks++;
         if (zo[37:19] !== e.z1) begin
            errors++;
            $display("FAIL %s z1: got %h, expected %h", e.name, zo[37:19], e.z1);
         end
         checks++;
         if (zo[18:0] !== e.z2) begin
            errors++;
            $display("FAIL %s z2: got %h, expected %h", e.name, zo[18:0], e.z2);
         end
         checks++;
         if (dbo !== e.db) begin
            errors++;
            $display("FAIL %s dly_b: got %h, expected %h", e.name, dbo, e.db);
         end
      end
   endtask

   task automatic drain;
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results never arrived, expected 0 outstanding", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset;
      lreset = 1'b0;
      #2;
      checks++;
      if (bus_m.z !== 38'h0) begin errors++; $display("FAIL reset_z: got %h, expected 0", bus_m.z); end
      checks++;
      if (bus_m.dly_b !== 18'h0) begin errors++; $display("FAIL reset_dly_b: got %h, expected 0", bus_m.dly_b); end
      checks++;
      if (bus_p.z !== 38'h0) begin errors++; $display("FAIL reset_mo_z: got %h, expected 0", bus_p.z); end
      checks++;
      if (bus_p.dly_b !== 18'h0) begin errors++; $display("FAIL reset_mo_dly_b: got %h, expected 0", bus_p.dly_b); end
      @(negedge clk);
      lreset = 1'b1;
   endtask

   task automatic test_basic_mac;
      tick();
      bus_m.a = {10'd3, 10'd0}; bus_m.b = {9'd5, 9'd0}; bus_m.load_acc = 1'b0;
      push("mac_load", 0, 19'd15, 19'd0);
      tick();
      bus_m.load_acc = 1'b1;
      push("mac_acc", 0, 19'd30, 19'd0);
      tick();
      idle_m();
      drain();
   endtask

   task automatic test_subtract_coeff;
      bus_m.a = {10'd3, 10'd0}; bus_m.b = {9'd5, 9'd0}; bus_m.subtract = 1'b1;
      push("subtract", 0, 19'h7FFF1, 19'd0);
      tick();
      idle_m();
      bus_m.feedback = 3'b101; bus_m.b = {9'd2, 9'd4};
      push("coeff_c1", 0, 19'd14, 19'h7FFFC);
      tick();
      idle_m();
      drain();
   endtask

   task automatic test_shift_round;
      bus_m.a = {10'd3, 10'd0}; bus_m.b = {9'd5, 9'd0};
      bus_m.shift_right = 5'd2; bus_m.round = 1'b1;
      push("shift_round", 0, 19'd4, 19'd0);
      tick();
      bus_m.round = 1'b0;
      push("shift_trunc", 0, 19'd3, 19'd0);
      tick();
      bus_m.shift_right = 5'd0; bus_m.round = 1'b1;
      push("round_noshift", 0, 19'd15, 19'd0);
      tick();
      idle_m();
      drain();
   endtask

   task automatic test_saturation;
      logic [18:0] s2, s3, u2, u3;
`ifdef DSP19X2_SPLIT_MAC_SAT_EN
      s2 = 19'h3FFFF; s3 = 19'h3FFFF; u2 = 19'h7FFFF; u3 = 19'h7FFFF;
`else
      s2 = 19'h40000; s3 = 19'h60000; u2 = 19'h7F402; u3 = 19'h7EE03;
`endif
      bus_m.a = {10'h200, 10'd0}; bus_m.b = {9'h100, 9'd0}; bus_m.saturate_enable = 1'b1;
      push("sat_s1", 0, 19'h20000, 19'd0);
      tick();
      bus_m.load_acc = 1'b1;
      push("sat_s2", 0, s2, 19'd0);
      tick();
      push("sat_s3", 0, s3, 19'd0);
      tick();
      bus_m.unsigned_a = 1'b1; bus_m.unsigned_b = 1'b1; bus_m.load_acc = 1'b0;
      bus_m.a = {10'd1023, 10'd0}; bus_m.b = {9'd511, 9'd0};
      push("sat_u1", 0, 19'h7FA01, 19'd0);
      tick();
      bus_m.load_acc = 1'b1;
      push("sat_u2", 0, u2, 19'd0);
      tick();
      push("sat_u3", 0, u3, 19'd0);
      tick();
      idle_m();
      drain();
   endtask

   task automatic test_reset_mid;
      bus_m.a = {10'd1, 10'd0}; bus_m.b = {9'd1, 9'd0};
      push("pre_rst1", 0, 19'd1, 19'd0);
      tick();
      bus_m.load_acc = 1'b1;
      push("pre_rst2", 0, 19'd2, 19'd0);
      tick();
      drain();
      #2;
      lreset = 1'b0;
      #1;
      checks++;
      if (bus_m.z !== 38'h0) begin errors++; $display("FAIL midrst_z: got %h, expected 0", bus_m.z); end
      checks++;
      if (bus_m.dly_b !== 18'h0) begin errors++; $display("FAIL midrst_dly_b: got %h, expected 0", bus_m.dly_b); end
      #1;
      lreset = 1'b1;
      push("rst_resume", 0, 19'd1, 19'd0);
      tick();
      idle_m();
      drain();
   endtask

   task automatic test_back_to_back;
      logic signed [9:0] ra1, ra2;
      logic signed [8:0] rb1, rb2;
      int                acc1, acc2;
      acc1 = 0;
      acc2 = 0;
      for (int i = 0; i < 6; i++) begin
         ra1 = 10'($urandom); ra2 = 10'($urandom);
         rb1 = 9'($urandom);  rb2 = 9'($urandom);
         acc1 = (i == 0) ? int'(ra1) * int'(rb1) : acc1 + int'(ra1) * int'(rb1);
         acc2 = (i == 0) ? int'(ra2) * int'(rb2) : acc2 + int'(ra2) * int'(rb2);
         bus_m.a = {ra1, ra2}; bus_m.b = {rb1, rb2}; bus_m.load_acc = (i != 0);
         push("b2b_mac", 0, acc1[18:0], acc2[18:0]);
         tick();
      end
      idle_m();
      drain();
   endtask

   task automatic test_mult_only;
      bus_p.a = {10'h3FE, 10'd0}; bus_p.b = {9'd9, 9'd0};
      push("mo_first", 1, 19'h7FFEE, 19'd0);
      tick();
      bus_p.a = {10'd5, 10'd7}; bus_p.b = {9'h1FD, 9'd3};
      push("mo_second", 1, 19'h7FFF1, 19'd21);
      tick();
      idle_p();
      drain();
   endtask

   initial begin
      idle_m();
      idle_p();
      test_reset();
      test_basic_mac();
      test_subtract_coeff();
      test_shift_round();
      test_saturation();
      test_reset_mid();
      test_back_to_back();
      test_mult_only();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
